// File: rtl/store_unit_pkg.sv
// Shared definitions for the RV32I store path: store widths, FSM encoding, legality check.
package store_unit_pkg;

   localparam int unsigned WORD_WIDTH  = 32;
   localparam int unsigned FUNC3_WIDTH = 3;

   localparam logic [FUNC3_WIDTH-1:0] FUNC3_SB = 3'b000;
   localparam logic [FUNC3_WIDTH-1:0] FUNC3_SH = 3'b001;
   localparam logic [FUNC3_WIDTH-1:0] FUNC3_SW = 3'b010;

   // Fixed encoding so cpu-level benches can probe the state value
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERR   = 3'd4
   } store_state_e;

   // A store is illegal for an unknown width or a misaligned half/word
   function automatic logic store_illegal(input logic [FUNC3_WIDTH-1:0] func3,
                                          input logic [1:0]             byte_off);
      logic bad;
      case (func3)
         FUNC3_SB: bad = 1'b0;
         FUNC3_SH: bad = byte_off[0];
         FUNC3_SW: bad = |byte_off;
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte/half insertion of store data into an existing little-endian word.
module store_merge
   import store_unit_pkg::*;
(
   input  logic [WORD_WIDTH-1:0]  old_word,
   input  logic [WORD_WIDTH-1:0]  wdata,
   input  logic [FUNC3_WIDTH-1:0] func3,
   input  logic [1:0]             byte_off,
   output logic [WORD_WIDTH-1:0]  merged_word
);

   // Overlay the addressed lane(s) on the old word; everything else passes through
   always_comb begin
      merged_word = old_word;
      case (func3)
         FUNC3_SB: begin
            case (byte_off)
               2'd0:    merged_word[7:0]   = wdata[7:0];
               2'd1:    merged_word[15:8]  = wdata[7:0];
               2'd2:    merged_word[23:16] = wdata[7:0];
               default: merged_word[31:24] = wdata[7:0];
            endcase
         end
         FUNC3_SH: begin
            if (byte_off[1]) merged_word[31:16] = wdata[15:0];
            else             merged_word[15:0]  = wdata[15:0];
         end
         FUNC3_SW: merged_word = wdata;
         default:  merged_word = old_word;
      endcase
   end

endmodule

// File: rtl/store_unit.sv
// RV32I store engine: SW writes directly, SB/SH read-modify-write through bram32.
module store_unit
   import store_unit_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic [2:0]             func3,
   input  logic [31:0]            addr,
   input  logic [DATA_WIDTH-1:0]  wdata,
   output logic                   stall,
   output logic                   done,
   output logic                   err,
   output logic [ADDR_WIDTH-1:0]  mem_r_addr,
   output logic                   mem_r_enb,
   input  logic [DATA_WIDTH-1:0]  mem_r_dat,
   output logic [ADDR_WIDTH-1:0]  mem_w_addr,
   output logic [DATA_WIDTH-1:0]  mem_w_dat,
   output logic                   mem_w_enb
);

   store_state_e           state;
   logic [2:0]             func3_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [ADDR_WIDTH-1:0]  req_word_addr;
   logic [ADDR_WIDTH-1:0]  word_addr;
   logic [DATA_WIDTH-1:0]  merged;
   logic                   unused_addr_hi;

   // Addresses wrap: bits above the BRAM address range are dropped
   assign unused_addr_hi = ^addr[31:ADDR_WIDTH];
   assign req_word_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
   assign word_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};

   store_merge u_merge (
      .old_word    (mem_r_dat),
      .wdata       (wdata_q),
      .func3       (func3_q),
      .byte_off    (addr_q[1:0]),
      .merged_word (merged)
   );

   // Stall must rise in the request cycle itself, so it is decoded from state and req
   assign stall = !rst && (((state == ST_IDLE) && req) ||
                           (state == ST_READ) || (state == ST_MERGE));

   // Store sequencer with registered memory-port and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         func3_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         mem_r_addr <= '0;
         mem_r_enb  <= 1'b0;
         mem_w_addr <= '0;
         mem_w_dat  <= '0;
         mem_w_enb  <= 1'b0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         mem_r_enb <= 1'b0;
         mem_w_enb <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  func3_q <= func3;
                  addr_q  <= addr[ADDR_WIDTH-1:0];
                  wdata_q <= wdata;
                  if (store_illegal(func3, addr[1:0])) begin
                     state <= ST_ERR;
                     err   <= 1'b1;
                  end else if (func3 == FUNC3_SW) begin
                     state      <= ST_WRITE;
                     done       <= 1'b1;
                     mem_w_enb  <= 1'b1;
                     mem_w_addr <= req_word_addr;
                     mem_w_dat  <= wdata;
                  end else begin
                     state      <= ST_READ;
                     mem_r_enb  <= 1'b1;
                     mem_r_addr <= req_word_addr;
                  end
               end
            end
            ST_READ: state <= ST_MERGE;
            ST_MERGE: begin
               state      <= ST_WRITE;
               done       <= 1'b1;
               mem_w_enb  <= 1'b1;
               mem_w_addr <= word_addr;
               mem_w_dat  <= merged;
            end
            ST_WRITE: state <= ST_IDLE;
            ST_ERR:   state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a registered-read bram32 model.
module tb_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [2:0]  func3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic        err;
   logic [9:0]  mem_r_addr;
   logic        mem_r_enb;
   logic [31:0] mem_r_dat;
   logic [9:0]  mem_w_addr;
   logic [31:0] mem_w_dat;
   logic        mem_w_enb;

   logic [31:0] mem [0:255];
   int checks = 0;
   int errors = 0;

   localparam logic [2:0] SB = 3'b000;
   localparam logic [2:0] SH = 3'b001;
   localparam logic [2:0] SW = 3'b010;

   store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .func3      (func3),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .done       (done),
      .err        (err),
      .mem_r_addr (mem_r_addr),
      .mem_r_enb  (mem_r_enb),
      .mem_r_dat  (mem_r_dat),
      .mem_w_addr (mem_w_addr),
      .mem_w_dat  (mem_w_dat),
      .mem_w_enb  (mem_w_enb)
   );

   always #5 clk = ~clk;

   // bram32 model: one-cycle registered read, synchronous write
   always @(posedge clk) begin
      if (mem_r_enb) mem_r_dat <= mem[mem_r_addr[9:2]];
      if (mem_w_enb) mem[mem_w_addr[9:2]] <= mem_w_dat;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to the next cycle, apply inputs, let combinational outputs settle
   task automatic drive(input logic r, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      req = r; func3 = f; addr = a; wdata = d;
      #1;
   endtask

   task automatic idle_cycle();
      drive(1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic sw_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] wa);
      drive(1'b1, SW, a, d);
      chk("sw_c0_stall", 32'(stall), 32'd1);
      chk("sw_c0_wenb", 32'(mem_w_enb), 32'd0);
      idle_cycle();
      chk("sw_c1_done", 32'(done), 32'd1);
      chk("sw_c1_wenb", 32'(mem_w_enb), 32'd1);
      chk("sw_c1_waddr", 32'(mem_w_addr), wa);
      chk("sw_c1_wdat", mem_w_dat, d);
      chk("sw_c1_stall", 32'(stall), 32'd0);
      chk("sw_c1_renb", 32'(mem_r_enb), 32'd0);
      idle_cycle();
      chk("sw_mem", mem[wa[9:2]], d);
   endtask

   task automatic rmw_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] wa, input logic [31:0] exp_word);
      drive(1'b1, f, a, d);
      chk("rmw_c0_stall", 32'(stall), 32'd1);
      idle_cycle();
      chk("rmw_c1_renb", 32'(mem_r_enb), 32'd1);
      chk("rmw_c1_raddr", 32'(mem_r_addr), wa);
      chk("rmw_c1_stall", 32'(stall), 32'd1);
      idle_cycle();
      chk("rmw_c2_stall", 32'(stall), 32'd1);
      chk("rmw_c2_wenb", 32'(mem_w_enb), 32'd0);
      chk("rmw_c2_renb", 32'(mem_r_enb), 32'd0);
      idle_cycle();
      chk("rmw_c3_done", 32'(done), 32'd1);
      chk("rmw_c3_wenb", 32'(mem_w_enb), 32'd1);
      chk("rmw_c3_waddr", 32'(mem_w_addr), wa);
      chk("rmw_c3_wdat", mem_w_dat, exp_word);
      chk("rmw_c3_stall", 32'(stall), 32'd0);
      idle_cycle();
      chk("rmw_mem", mem[wa[9:2]], exp_word);
   endtask

   task automatic err_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, f, a, d);
      chk("err_c0_stall", 32'(stall), 32'd1);
      idle_cycle();
      chk("err_c1_err", 32'(err), 32'd1);
      chk("err_c1_done", 32'(done), 32'd0);
      chk("err_c1_wenb", 32'(mem_w_enb), 32'd0);
      chk("err_c1_renb", 32'(mem_r_enb), 32'd0);
      chk("err_c1_stall", 32'(stall), 32'd0);
      idle_cycle();
      chk("err_c2_err", 32'(err), 32'd0);
      chk("err_c2_wenb", 32'(mem_w_enb), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; func3 = 3'b000; addr = 32'h0; wdata = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'hCAFEF00D;
      mem[1] = 32'h11223344;
      mem[3] = 32'h00000004;
      mem[4] = 32'h55555555;

      // Reset state
      @(negedge clk); #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_wenb", 32'(mem_w_enb), 32'd0);
      chk("rst_renb", 32'(mem_r_enb), 32'd0);
      chk("rst_wdat", mem_w_dat, 32'h0);
      rst = 1'b0;
      idle_cycle();
      chk("idle_stall", 32'(stall), 32'd0);

      // SW aligned
      sw_store(32'h8, 32'hDEADBEEF, 32'h008);

      // SB into each lane of 0x11223344
      rmw_store(SB, 32'h4, 32'h000000AB, 32'h004, 32'h112233AB);
      rmw_store(SB, 32'h5, 32'h000000AB, 32'h004, 32'h1122ABAB);
      rmw_store(SB, 32'h6, 32'h000000AB, 32'h004, 32'h11ABABAB);
      rmw_store(SB, 32'h7, 32'h000000AB, 32'h004, 32'hABABABAB);

      // SH upper half; upper wdata bits must not leak
      rmw_store(SH, 32'hE, 32'hFFFF1234, 32'h00C, 32'h12340004);

      // Misaligned and illegal stores
      err_store(SW, 32'h6, 32'h99999999);
      err_store(SH, 32'h3, 32'h99999999);
      err_store(3'b011, 32'h0, 32'h99999999);
      chk("err_mem0", mem[0], 32'hCAFEF00D);
      chk("err_mem1", mem[1], 32'hABABABAB);
      chk("err_mem3", mem[3], 32'h12340004);

      // Reset asserted in the MERGE cycle of an SB
      drive(1'b1, SB, 32'h10, 32'h00000077);
      idle_cycle();
      chk("rmid_c1_renb", 32'(mem_r_enb), 32'd1);
      idle_cycle();
      chk("rmid_c2_stall", 32'(stall), 32'd1);
      rst = 1'b1;
      #1;
      chk("rmid_stall", 32'(stall), 32'd0);
      chk("rmid_done", 32'(done), 32'd0);
      chk("rmid_wenb", 32'(mem_w_enb), 32'd0);
      chk("rmid_renb", 32'(mem_r_enb), 32'd0);
      chk("rmid_raddr", 32'(mem_r_addr), 32'h0);
      chk("rmid_wdat", mem_w_dat, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle_cycle();
      chk("rmid_mem4", mem[4], 32'h55555555);
      chk("rmid_wenb2", 32'(mem_w_enb), 32'd0);
      sw_store(32'h0, 32'h0BADC0DE, 32'h000);

      // Address wrap: bits above ADDR_WIDTH ignored
      sw_store(32'h0000_0408, 32'h0F0F0F0F, 32'h008);

      // Back-to-back: req held through WRITE, next SB on the cycle after done
      drive(1'b1, SW, 32'h0, 32'h12345678);
      chk("b2b_c0_stall", 32'(stall), 32'd1);
      drive(1'b1, SW, 32'h0, 32'h12345678);
      chk("b2b_c1_done", 32'(done), 32'd1);
      chk("b2b_c1_wdat", mem_w_dat, 32'h12345678);
      chk("b2b_c1_stall", 32'(stall), 32'd0);
      drive(1'b1, SB, 32'h1, 32'h0000009A);
      chk("b2b_c2_wenb", 32'(mem_w_enb), 32'd0);
      chk("b2b_c2_done", 32'(done), 32'd0);
      chk("b2b_c2_stall", 32'(stall), 32'd1);
      idle_cycle();
      chk("b2b_c3_renb", 32'(mem_r_enb), 32'd1);
      chk("b2b_c3_wenb", 32'(mem_w_enb), 32'd0);
      idle_cycle();
      chk("b2b_c4_wenb", 32'(mem_w_enb), 32'd0);
      idle_cycle();
      chk("b2b_c5_done", 32'(done), 32'd1);
      chk("b2b_c5_wenb", 32'(mem_w_enb), 32'd1);
      chk("b2b_c5_waddr", 32'(mem_w_addr), 32'h000);
      chk("b2b_c5_wdat", mem_w_dat, 32'h12349A78);
      idle_cycle();
      chk("b2b_mem0", mem[0], 32'h12349A78);
      chk("b2b_idle_stall", 32'(stall), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Executes the memory-write side of RV32I stores (sb, sh, sw) against the data BRAM (bram32). It is the write-direction counterpart of the load path.
- Accepts a store request from the control/ALU path and drives the bram32 write port directly.
- sb/sh: performs read-modify-write through the bram32 read port.
- sw: writes the full word directly.
- Holds the PC stalled until the write is issued.

Parameters:
- ADDR_WIDTH, 10: bram32 byte-address width on the memory side.
- DATA_WIDTH, 32: data word width, from `DATA_WIDTH.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req, in, 1: store request (mem_write from control); level-sensitive.
- func3, in, 3: store width; 000 = SB, 001 = SH, 010 = SW.
- addr, in, 32: byte address (ALU result).
- wdata, in, 32: store data (rs2).
- stall, out, 1: freezes PC while a store is in progress.
- done, out, 1: one-cycle pulse in the cycle the write is issued.
- err, out, 1: one-cycle pulse when a store is misaligned or has an illegal func3.
- mem_r_addr, out, ADDR_WIDTH: bram32 read address.
- mem_r_enb, out, 1: bram32 read enable.
- mem_r_dat, in, 32: bram32 read data, valid 1 cycle after mem_r_enb.
- mem_w_addr, out, ADDR_WIDTH: bram32 write address.
- mem_w_dat, out, 32: bram32 write data.
- mem_w_enb, out, 1: bram32 write enable.

Behaviour:
- Reset (async, any state): go to IDLE; all outputs and internal registers to 0. Any in-flight read or write is abandoned and nothing is written.
- FSM states: IDLE, READ, MERGE, WRITE, ERR.
- IDLE:
  - req=0: stay in IDLE; stall=0.
  - req=1: stall=1 combinationally in this same cycle. Capture func3, addr and wdata.
  - Word address = {addr[ADDR_WIDTH-1:2], 2'b00}. addr bits at and above ADDR_WIDTH are ignored, so addresses wrap.
  - Next state: ERR if the store is illegal; WRITE for SW; READ for SB/SH.
- Illegal store: func3 not in {000, 001, 010}, or SH with addr[0]=1, or SW with addr[1:0]!=0.
- READ:
  - mem_r_enb=1, mem_r_addr=word address, stall=1.
  - Next state: MERGE.
- MERGE:
  - mem_r_dat is valid; stall=1.
  - Merged word is registered into mem_w_dat. Byte lanes are little-endian.
  - SB: lane k=addr[1:0]; bits [8k+7:8k] = wdata[7:0].
  - SH: half h=addr[1]; bits [16h+15:16h] = wdata[15:0].
  - All other bits come from mem_r_dat.
  - Next state: WRITE.
- WRITE:
  - mem_w_enb=1, mem_w_addr=word address, done=1, stall=0.
  - SW writes wdata unmodified.
  - Next state: IDLE. req is ignored in this cycle.
  - PC advances at the end of this cycle.
- ERR:
  - err=1, stall=0, no memory access.
  - Next state: IDLE.
- Latency, counted from the request cycle (cycle 0):
  - SW: write in cycle 1; stall high in cycle 0 only.
  - SB/SH: write in cycle 3; stall high in cycles 0-2.
  - Error: err in cycle 1.
- req is sampled only in IDLE. A req held high across WRITE/ERR does not retrigger. A req still high in the following IDLE cycle starts a new store, which is correct for back-to-back stores because the PC has advanced.
- Outputs when idle: mem_r_enb=0, mem_w_enb=0. mem_w_dat and mem_w_addr hold their last values (don't-care while mem_w_enb=0).
- done and err are never high in the same cycle. mem_r_enb and mem_w_enb are never high in the same cycle.

Decomposition:
- FUNC3_SB/SH/SW constants go in rv32i_control.vh.
- Store state encoding (3-bit localparams) goes in rv32i_params.vh, so cpu-level benches can probe the state.
- One combinational sub-module, store_merge, with inputs (old_word, wdata, func3, byte_off[1:0]) and output merged_word. It is reused by a future cache or write-buffer.

Test Plan:
- SW aligned:
  - Stimulus: req=1, func3=010, addr=0x8, wdata=0xDEADBEEF.
  - Response: cycle 1 has mem_w_enb=1, mem_w_addr=0x008, mem_w_dat=0xDEADBEEF, done=1; stall high only in cycle 0; mem_r_enb never asserted.
- SB into each lane:
  - Stimulus: memory word at 0x4 preloaded with 0x11223344; SB wdata=0xAB at addr 0x4, 0x5, 0x6, 0x7 in sequence.
  - Response: final word is 0xABABABAB. Intermediate words are 0x112233AB, then 0x1122ABAB, then 0x11ABABAB. Each store has done in cycle 3 and stall in cycles 0-2.
- SH upper half:
  - Stimulus: memory word at 0xC preloaded with 0x00000004; SH wdata=0xFFFF1234, addr=0xE.
  - Response: written word is 0x12340004; mem_r_enb=1 in cycle 1.
- Misaligned and illegal:
  - Stimulus: SW addr=0x6; SH addr=0x3; func3=011 addr=0x0.
  - Response: each gives err=1 in cycle 1; mem_w_enb stays 0; memory unchanged.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously in the MERGE cycle of an SB.
  - Response: all outputs go to 0 immediately with no write; after release, a new SW to 0x0 completes normally.
- Back-to-back:
  - Stimulus: req held high with SW 0x0, then SB 0x1 presented on the cycle after done.
  - Response: two writes occur, in cycles 1 and 5; no spurious retrigger in the WRITE cycle.
